// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian data memory for the MEM stage: byte/half/word
// loads and stores, valid/ready request, one-cycle response after WAIT extra cycles.
module data_mem_sized #(
   parameter int N     = 32,
   parameter int DEPTH = 32,
   parameter int WAIT  = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [1:0]   req_size,
   input  logic         req_uns,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         rsp_valid,
   output logic [N-1:0] rsp_rdata,
   output logic         rsp_err
);
   localparam int IDX = $clog2(DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef logic [DEPTH-1:0][N-1:0] mem_t;

   function automatic mem_t init_mem();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) m[i] = N'(i);
      return m;
   endfunction

   // Power-up image; reset deliberately leaves the array alone.
   mem_t mem = init_mem();

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic           l_we, l_uns;
   logic [1:0]     l_size;
   logic [N-1:0]   l_addr, l_wdata;

   logic           accept, commit;
   logic           c_we, c_uns;
   logic [1:0]     c_size;
   logic [N-1:0]   c_addr, c_wdata;
   logic [IDX-1:0] widx;
   logic [1:0]     lane;
   logic [N-1:0]   word, load_val, store_val, wd_rep;
   logic [7:0]     byte_v;
   logic [15:0]    half_v;
   logic [3:0]     be;
   logic           err;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign commit    = (WAIT == 0) ? accept : (state == BUSY && cnt == 4'd1);

   // With no wait states the access commits on the accept edge, so it uses the live inputs.
   assign c_we    = (WAIT == 0) ? req_we    : l_we;
   assign c_uns   = (WAIT == 0) ? req_uns   : l_uns;
   assign c_size  = (WAIT == 0) ? req_size  : l_size;
   assign c_addr  = (WAIT == 0) ? req_addr  : l_addr;
   assign c_wdata = (WAIT == 0) ? req_wdata : l_wdata;

   assign widx   = c_addr[IDX+1:2];
   assign lane   = c_addr[1:0];
   assign word   = mem[widx];
   assign byte_v = word[{lane, 3'b000} +: 8];
   assign half_v = word[{c_addr[1], 4'b0000} +: 16];

   assign err = (c_size == 2'b11)
              | (c_size == 2'b01 && c_addr[0])
              | (c_size == 2'b10 && lane != 2'b00)
              | (|c_addr[N-1:IDX+2]);

   always_comb begin
      load_val = word;
      wd_rep   = c_wdata;
      be       = 4'b1111;
      case (c_size)
         2'b00: begin
            load_val = {{(N-8){~c_uns & byte_v[7]}}, byte_v};
            wd_rep   = {4{c_wdata[7:0]}};
            be       = 4'b0001 << lane;
         end
         2'b01: begin
            load_val = {{(N-16){~c_uns & half_v[15]}}, half_v};
            wd_rep   = {2{c_wdata[15:0]}};
            be       = c_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Lanes are replicated first, then the byte enables pick which ones land.
   always_comb begin
      store_val = word;
      for (int i = 0; i < 4; i++)
         if (be[i]) store_val[8*i +: 8] = wd_rep[8*i +: 8];
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (accept && WAIT > 0) begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(WAIT);
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rsp_valid <= commit;
         if (commit) begin
            rsp_err   <= err;
            rsp_rdata <= (!c_we && !err) ? load_val : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         l_we    <= req_we;
         l_uns   <= req_uns;
         l_size  <= req_size;
         l_addr  <= req_addr;
         l_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && commit && c_we && !err) mem[widx] <= store_val;
   end
endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: three instances (WAIT 0/2/3) checked against a
// byte-array reference model with directed and random accesses.
module tb_data_mem_sized;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst       [NI];
   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_we    [NI];
   logic [1:0]  req_size  [NI];
   logic        req_uns   [NI];
   logic [31:0] req_addr  [NI];
   logic [31:0] req_wdata [NI];
   logic        rsp_valid [NI];
   logic [31:0] rsp_rdata [NI];
   logic        rsp_err   [NI];

   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] mb [NI][128];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
      data_mem_sized #(.N(32), .DEPTH(32), .WAIT(W)) u_dut (
         .clk(clk), .rst(rst[g]),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_we(req_we[g]), .req_size(req_size[g]), .req_uns(req_uns[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
         .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]));
   end

   function automatic int wait_of(int inst);
      return (inst == 0) ? 0 : (inst == 1) ? 2 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference: memory as bytes, access semantics from the size/address rules.
   task automatic model(input int inst, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] xd, output logic xe);
      int nb;
      logic [31:0] v;
      xe = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
           || ((addr >> 2) >= 32);
      xd = 32'h0;
      if (xe) return;
      nb = 1 << size;
      if (we) begin
         for (int i = 0; i < nb; i++) mb[inst][addr + i] = 8'(wdata >> (8 * i));
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(mb[inst][addr + i]) << (8 * i));
         if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         xd = v;
      end
   endtask

   task automatic access(input int inst, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got);
      logic [31:0] xd;
      logic        xe;
      int          n, lat;
      model(inst, we, size, uns, addr, wdata, xd, xe);
      @(negedge clk);
      req_valid[inst] = 1'b1; req_we[inst] = we; req_size[inst] = size;
      req_uns[inst] = uns; req_addr[inst] = addr; req_wdata[inst] = wdata;
      n = 0;
      while (!req_ready[inst] && n < 50) begin @(negedge clk); n++; end
      chk("ready", 32'(req_ready[inst]), 32'd1);
      @(posedge clk); #1;
      // Scramble the inputs while the access is in flight; they must be ignored.
      req_we[inst] = ~we; req_addr[inst] = $urandom; req_wdata[inst] = $urandom;
      req_size[inst] = 2'($urandom); req_uns[inst] = ~uns;
      lat = 0;
      while (!rsp_valid[inst] && lat < 20) begin
         chk("busy_ready", 32'(req_ready[inst]), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      req_valid[inst] = 1'b0;
      chk("latency", 32'(lat), 32'(wait_of(inst)));
      chk("rsp_err", 32'(rsp_err[inst]), 32'(xe));
      chk("rsp_rdata", rsp_rdata[inst], xd);
      got = rsp_rdata[inst];
      @(posedge clk); #1;
      chk("pulse", 32'(rsp_valid[inst]), 32'd0);
      chk("hold", rsp_rdata[inst], xd);
   endtask

   logic [31:0] got;
   int          seen;
   logic [1:0]  rs;
   logic [31:0] ra;

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
         req_uns[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
         for (int b = 0; b < 128; b++) mb[i][b] = (b % 4 == 0) ? 8'(b / 4) : 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("rst_ready", 32'(req_ready[i]), 32'd0);
         chk("rst_valid", 32'(rsp_valid[i]), 32'd0);
         chk("rst_rdata", rsp_rdata[i], 32'd0);
         chk("rst_err", 32'(rsp_err[i]), 32'd0);
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) rst[i] = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) chk("idle_ready", 32'(req_ready[i]), 32'd1);

      // Directed loads/stores on the zero-wait instance.
      access(0, 0, 2'd2, 0, 32'h14, 0, got);           chk("lw14", got, 32'h0000_0005);
      access(0, 1, 2'd0, 0, 32'h15, 32'hAB, got);
      access(0, 0, 2'd2, 0, 32'h14, 0, got);           chk("lw14b", got, 32'h0000_AB05);
      access(0, 0, 2'd0, 0, 32'h15, 0, got);           chk("lb15", got, 32'hFFFF_FFAB);
      access(0, 0, 2'd0, 1, 32'h15, 0, got);           chk("lbu15", got, 32'h0000_00AB);
      access(0, 1, 2'd1, 0, 32'h1A, 32'h8001, got);
      access(0, 0, 2'd1, 0, 32'h1A, 0, got);           chk("lh1a", got, 32'hFFFF_8001);
      access(0, 0, 2'd1, 1, 32'h1A, 0, got);           chk("lhu1a", got, 32'h0000_8001);
      access(0, 0, 2'd2, 0, 32'h18, 0, got);           chk("lw18", got, 32'h8001_0006);
      access(0, 0, 2'd2, 0, 32'h16, 0, got);
      access(0, 1, 2'd1, 0, 32'h21, 32'hFFFF, got);
      access(0, 1, 2'd3, 0, 32'h20, 32'hFFFF_FFFF, got);
      access(0, 1, 2'd2, 0, 32'h80, 32'h1234_5678, got);
      access(0, 0, 2'd2, 0, 32'h20, 0, got);           chk("lw20", got, 32'h0000_0008);
      access(0, 0, 2'd2, 0, 32'h00, 0, got);           chk("lw00", got, 32'h0000_0000);

      // Wait-state store followed by a read-back.
      access(1, 1, 2'd2, 0, 32'h08, 32'hDEAD_BEEF, got);
      access(1, 0, 2'd2, 0, 32'h08, 0, got);           chk("lw08", got, 32'hDEAD_BEEF);

      // Reset mid-access drops the store and the response.
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
      req_uns[2] = 1'b0; req_addr[2] = 32'h0C; req_wdata[2] = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid[2]) seen++;
         @(posedge clk); #1;
      end
      chk("rst_drop", 32'(seen), 32'd0);
      chk("rst_mid_ready", 32'(req_ready[2]), 32'd1);
      access(2, 0, 2'd2, 0, 32'h0C, 0, got);           chk("lw0c", got, 32'h0000_0003);

      // Random traffic on every instance.
      for (int i = 0; i < NI; i++) begin
         for (int t = 0; t < 80; t++) begin
            rs = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 2) != 0 && rs != 2'd3 && ra < 128)
               ra = ra & ~((32'd1 << rs) - 32'd1);
            access(i, 1'($urandom), rs, 1'($urandom), ra, $urandom, got);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
